proc_scheduler: RTL and testbench

- Context scheduler for the dual-context program counter (OS context / process context).
- Drives the PC's proc_num, change_proc_pc and stored_pc inputs.
- Holds a per-process saved-PC table and dispatches processes on OS request.
- Returns control to the OS on process syscall, process exit or quantum expiry, saving the process PC on the way out.

---
 rtl/proc_scheduler.sv | 143 ++++++++++++++
 tb/tb_proc_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_scheduler.sv
// Context scheduler for the dual-context PC: dispatches processes from a saved-PC
// table and returns control to the OS on syscall, exit or quantum expiry (PREEMPT_EN).
module proc_scheduler #(
  parameter int PID_W = 2,
  parameter int QW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hlt,
  input  logic             dispatch_req,
  input  logic [PID_W-1:0] dispatch_pid,
  input  logic [QW-1:0]    quantum_in,
  input  logic             syscall,
  input  logic             proc_exit,
  input  logic [9:0]       proc_pc,
  input  logic             tbl_we,
  input  logic [PID_W-1:0] tbl_pid,
  input  logic [9:0]       tbl_pc,
  output logic             proc_num,
  output logic             change_proc_pc,
  output logic [9:0]       stored_pc,
  output logic [PID_W-1:0] cur_pid,
  output logic             trap_irq,
  output logic [1:0]       trap_cause
);

  // state    | meaning
  // OS_RUN   | OS context runs, waits for a dispatch request
  // LOAD_PC  | strobe the saved PC of cur_pid into the process PC
  // PROC_RUN | process context runs until syscall, exit or expiry
  // SAVE_PC  | write the frozen process PC back, pulse trap_irq

  localparam int NUM_PROCS = 2 ** PID_W;

  localparam logic [1:0] CAUSE_SYSCALL = 2'd1;
  localparam logic [1:0] CAUSE_QUANTUM = 2'd2;
  localparam logic [1:0] CAUSE_EXIT    = 2'd3;

  typedef enum logic [1:0] {
    OS_RUN   = 2'd0,
    LOAD_PC  = 2'd1,
    PROC_RUN = 2'd2,
    SAVE_PC  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cause_nxt;
  logic [9:0] stored_pc_q;
  logic [9:0] tbl [NUM_PROCS];
  logic       dispatch_go;
  logic       expire;

`ifdef PREEMPT_EN
  logic [QW-1:0] qcnt;

  // Expiry fires on the quantum_in-th retiring cycle; a halted cycle does not count.
  assign expire = (qcnt == QW'(1)) && !hlt;
`else
  logic unused_quantum;

  assign unused_quantum = ^quantum_in;
  assign expire         = 1'b0;
`endif

  assign dispatch_go = (state == OS_RUN) && dispatch_req && !hlt;

  always_comb begin
    state_nxt = state;
    cause_nxt = 2'd0;
    case (state)
      OS_RUN: begin
        if (dispatch_go) state_nxt = LOAD_PC;
      end
      LOAD_PC: begin
        state_nxt = PROC_RUN;
      end
      PROC_RUN: begin
        if (proc_exit) begin
          cause_nxt = CAUSE_EXIT;
          state_nxt = SAVE_PC;
        end else if (syscall) begin
          cause_nxt = CAUSE_SYSCALL;
          state_nxt = SAVE_PC;
        end else if (expire) begin
          cause_nxt = CAUSE_QUANTUM;
          state_nxt = SAVE_PC;
        end
      end
      SAVE_PC: begin
        state_nxt = OS_RUN;
      end
      default: begin
        state_nxt = OS_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= OS_RUN;
      cur_pid     <= '0;
      stored_pc_q <= '0;
      trap_cause  <= '0;
      for (int i = 0; i < NUM_PROCS; i++) tbl[i] <= '0;
`ifdef PREEMPT_EN
      qcnt        <= '0;
`endif
    end else begin
      state <= state_nxt;

      if (dispatch_go) begin
        cur_pid <= dispatch_pid;
`ifdef PREEMPT_EN
        qcnt    <= quantum_in;
`endif
      end

      if (state == LOAD_PC) begin
        stored_pc_q <= tbl[cur_pid];
        trap_cause  <= '0;
      end

      if (state == PROC_RUN) begin
        if (state_nxt == SAVE_PC) trap_cause <= cause_nxt;
`ifdef PREEMPT_EN
        if (!hlt && (qcnt != '0)) qcnt <= qcnt - QW'(1);
`endif
      end

      // The save-back is written after the OS port so it wins on an index collision.
      if (tbl_we) tbl[tbl_pid] <= tbl_pc;
      if (state == SAVE_PC) tbl[cur_pid] <= (trap_cause == CAUSE_EXIT) ? 10'd0 : proc_pc;
    end
  end

  assign proc_num       = (state == PROC_RUN);
  assign change_proc_pc = (state == LOAD_PC);
  assign trap_irq       = (state == SAVE_PC);
  // The table is read live during the strobe so a write in the dispatch cycle is seen.
  assign stored_pc      = change_proc_pc ? tbl[cur_pid] : stored_pc_q;

endmodule

// File: tb/tb_proc_scheduler.sv
// Directed self-checking bench for proc_scheduler; inputs change and outputs are
// sampled on the falling clock edge.
module tb_proc_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       hlt;
  logic       dispatch_req;
  logic [1:0] dispatch_pid;
  logic [7:0] quantum_in;
  logic       syscall;
  logic       proc_exit;
  logic [9:0] proc_pc;
  logic       tbl_we;
  logic [1:0] tbl_pid;
  logic [9:0] tbl_pc;
  logic       proc_num;
  logic       change_proc_pc;
  logic [9:0] stored_pc;
  logic [1:0] cur_pid;
  logic       trap_irq;
  logic [1:0] trap_cause;

  int checks = 0;
  int errors = 0;

  logic [9:0] spc;
  logic       chg;
  logic       pn;

  always #5 clk = ~clk;

  proc_scheduler #(.PID_W(2), .QW(8)) dut (
    .clk(clk), .reset(reset), .hlt(hlt),
    .dispatch_req(dispatch_req), .dispatch_pid(dispatch_pid), .quantum_in(quantum_in),
    .syscall(syscall), .proc_exit(proc_exit), .proc_pc(proc_pc),
    .tbl_we(tbl_we), .tbl_pid(tbl_pid), .tbl_pc(tbl_pc),
    .proc_num(proc_num), .change_proc_pc(change_proc_pc), .stored_pc(stored_pc),
    .cur_pid(cur_pid), .trap_irq(trap_irq), .trap_cause(trap_cause)
  );

  // Dispatch, capture the LOAD_PC cycle outputs, return in the first PROC_RUN cycle.
  task automatic do_dispatch(input logic [1:0] pid, input logic [7:0] q,
                             output logic [9:0] o_spc, output logic o_chg, output logic o_pn);
    dispatch_req = 1'b1; dispatch_pid = pid; quantum_in = q;
    @(negedge clk);
    dispatch_req = 1'b0;
    o_spc = stored_pc; o_chg = change_proc_pc;
    @(negedge clk);
    o_pn = proc_num;
  endtask

  // Trap out via syscall; returns in the first OS_RUN cycle.
  task automatic do_syscall(input logic [9:0] pc);
    proc_pc = pc; syscall = 1'b1;
    @(negedge clk);
    syscall = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (proc_num !== 1'b0) begin errors++; $display("FAIL reset_proc_num: got %0b expected 0", proc_num); end
    checks++; if (change_proc_pc !== 1'b0) begin errors++; $display("FAIL reset_change: got %0b expected 0", change_proc_pc); end
    checks++; if (stored_pc !== 10'h000) begin errors++; $display("FAIL reset_stored_pc: got %h expected 000", stored_pc); end
    checks++; if (trap_irq !== 1'b0) begin errors++; $display("FAIL reset_trap_irq: got %0b expected 0", trap_irq); end
    checks++; if (trap_cause !== 2'd0) begin errors++; $display("FAIL reset_trap_cause: got %0d expected 0", trap_cause); end
    checks++; if (cur_pid !== 2'd0) begin errors++; $display("FAIL reset_cur_pid: got %0d expected 0", cur_pid); end
    reset = 1'b1;
    do_dispatch(2'd3, 8'd0, spc, chg, pn);
    checks++; if (chg !== 1'b1) begin errors++; $display("FAIL reset_disp_change: got %0b expected 1", chg); end
    checks++; if (spc !== 10'h000) begin errors++; $display("FAIL reset_disp_stored_pc: got %h expected 000", spc); end
    checks++; if (pn !== 1'b1) begin errors++; $display("FAIL reset_disp_proc_num: got %0b expected 1", pn); end
    checks++; if (cur_pid !== 2'd3) begin errors++; $display("FAIL reset_disp_cur_pid: got %0d expected 3", cur_pid); end
    proc_pc = 10'h123; syscall = 1'b1;
    @(negedge clk);
    syscall = 1'b0;
    checks++; if (proc_num !== 1'b0) begin errors++; $display("FAIL syscall_proc_num: got %0b expected 0", proc_num); end
    checks++; if (trap_irq !== 1'b1) begin errors++; $display("FAIL syscall_trap_irq: got %0b expected 1", trap_irq); end
    checks++; if (trap_cause !== 2'd1) begin errors++; $display("FAIL syscall_cause: got %0d expected 1", trap_cause); end
    @(negedge clk);
    checks++; if (trap_irq !== 1'b0) begin errors++; $display("FAIL syscall_irq_pulse: got %0b expected 0", trap_irq); end
  endtask

  task automatic test_preset_dispatch();
    checks++; if (trap_cause !== 2'd1) begin errors++; $display("FAIL cause_held: got %0d expected 1", trap_cause); end
    tbl_we = 1'b1; tbl_pid = 2'd2; tbl_pc = 10'h1A4;
    @(negedge clk);
    tbl_we = 1'b0;
    do_dispatch(2'd2, 8'd0, spc, chg, pn);
    checks++; if (chg !== 1'b1) begin errors++; $display("FAIL preset_change: got %0b expected 1", chg); end
    checks++; if (spc !== 10'h1A4) begin errors++; $display("FAIL preset_stored_pc: got %h expected 1a4", spc); end
    checks++; if (pn !== 1'b1) begin errors++; $display("FAIL preset_proc_num: got %0b expected 1", pn); end
    checks++; if (trap_cause !== 2'd0) begin errors++; $display("FAIL preset_cause_clear: got %0d expected 0", trap_cause); end
    do_syscall(10'h1A4);
  endtask

  task automatic test_write_in_dispatch_cycle();
    tbl_we = 1'b1; tbl_pid = 2'd2; tbl_pc = 10'h2B5;
    do_dispatch(2'd2, 8'd0, spc, chg, pn);
    tbl_we = 1'b0;
    checks++; if (spc !== 10'h2B5) begin errors++; $display("FAIL same_cycle_write: got %h expected 2b5", spc); end
    do_syscall(10'h2B5);
  endtask

  task automatic test_hlt_dispatch_ignored();
    hlt = 1'b1; dispatch_req = 1'b1; dispatch_pid = 2'd1; quantum_in = 8'd0;
    @(negedge clk);
    checks++; if (change_proc_pc !== 1'b0) begin errors++; $display("FAIL hlt_dispatch_change: got %0b expected 0", change_proc_pc); end
    @(negedge clk);
    dispatch_req = 1'b0; hlt = 1'b0;
    checks++; if (proc_num !== 1'b0) begin errors++; $display("FAIL hlt_dispatch_proc_num: got %0b expected 0", proc_num); end
    checks++; if (cur_pid !== 2'd2) begin errors++; $display("FAIL hlt_dispatch_cur_pid: got %0d expected 2", cur_pid); end
    @(negedge clk);
  endtask

  task automatic test_quantum();
    proc_pc = 10'h050;
    do_dispatch(2'd1, 8'd5, spc, chg, pn);
`ifdef PREEMPT_EN
    repeat (4) @(negedge clk);
    checks++; if (proc_num !== 1'b1) begin errors++; $display("FAIL quantum_cycle5: got %0b expected 1", proc_num); end
    @(negedge clk);
    checks++; if (proc_num !== 1'b0) begin errors++; $display("FAIL quantum_expire: got %0b expected 0", proc_num); end
    checks++; if (trap_irq !== 1'b1) begin errors++; $display("FAIL quantum_irq: got %0b expected 1", trap_irq); end
    checks++; if (trap_cause !== 2'd2) begin errors++; $display("FAIL quantum_cause: got %0d expected 2", trap_cause); end
    @(negedge clk);
    checks++; if (trap_irq !== 1'b0) begin errors++; $display("FAIL quantum_irq_once: got %0b expected 0", trap_irq); end
    do_dispatch(2'd1, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h050) begin errors++; $display("FAIL quantum_saved_pc: got %h expected 050", spc); end
    do_syscall(10'h050);
    do_dispatch(2'd1, 8'd5, spc, chg, pn);
    hlt = 1'b1;
    repeat (3) @(negedge clk);
    hlt = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (proc_num !== 1'b1) begin errors++; $display("FAIL quantum_hlt_cycle8: got %0b expected 1", proc_num); end
    @(negedge clk);
    checks++; if (trap_cause !== 2'd2) begin errors++; $display("FAIL quantum_hlt_cause: got %0d expected 2", trap_cause); end
    checks++; if (trap_irq !== 1'b1) begin errors++; $display("FAIL quantum_hlt_irq: got %0b expected 1", trap_irq); end
    @(negedge clk);
    do_dispatch(2'd1, 8'd1, spc, chg, pn);
    @(negedge clk);
    checks++; if (trap_irq !== 1'b1) begin errors++; $display("FAIL quantum_one: got %0b expected 1", trap_irq); end
    @(negedge clk);
`else
    repeat (12) @(negedge clk);
    checks++; if (proc_num !== 1'b1) begin errors++; $display("FAIL no_preempt_proc_num: got %0b expected 1", proc_num); end
    checks++; if (trap_irq !== 1'b0) begin errors++; $display("FAIL no_preempt_irq: got %0b expected 0", trap_irq); end
    syscall = 1'b1;
    @(negedge clk);
    syscall = 1'b0;
    checks++; if (trap_cause !== 2'd1) begin errors++; $display("FAIL no_preempt_cause: got %0d expected 1", trap_cause); end
    @(negedge clk);
    do_dispatch(2'd1, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h050) begin errors++; $display("FAIL no_preempt_saved_pc: got %h expected 050", spc); end
    do_syscall(10'h050);
`endif
  endtask

  task automatic test_exit_priority();
    tbl_we = 1'b1; tbl_pid = 2'd1; tbl_pc = 10'h222;
    @(negedge clk);
    tbl_we = 1'b0;
    do_dispatch(2'd1, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h222) begin errors++; $display("FAIL exit_preload: got %h expected 222", spc); end
    proc_pc = 10'h111; syscall = 1'b1; proc_exit = 1'b1; hlt = 1'b1;
    @(negedge clk);
    syscall = 1'b0; proc_exit = 1'b0; hlt = 1'b0;
    checks++; if (trap_cause !== 2'd3) begin errors++; $display("FAIL exit_cause: got %0d expected 3", trap_cause); end
    checks++; if (proc_num !== 1'b0) begin errors++; $display("FAIL exit_proc_num: got %0b expected 0", proc_num); end
    @(negedge clk);
    do_dispatch(2'd1, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h000) begin errors++; $display("FAIL exit_cleared_pc: got %h expected 000", spc); end
    do_syscall(10'h0AA);
  endtask

  task automatic test_collision();
    do_dispatch(2'd0, 8'd0, spc, chg, pn);
    proc_pc = 10'h077; syscall = 1'b1;
    @(negedge clk);
    syscall = 1'b0;
    tbl_we = 1'b1; tbl_pid = 2'd0; tbl_pc = 10'h3FF;
    @(negedge clk);
    tbl_we = 1'b0;
    do_dispatch(2'd0, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h077) begin errors++; $display("FAIL collision: got %h expected 077", spc); end
    do_syscall(10'h077);
  endtask

  task automatic test_back_to_back();
    do_dispatch(2'd3, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h123) begin errors++; $display("FAIL b2b_pid3: got %h expected 123", spc); end
    do_syscall(10'h123);
    do_dispatch(2'd2, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h2B5) begin errors++; $display("FAIL b2b_pid2: got %h expected 2b5", spc); end
    checks++; if (pn !== 1'b1) begin errors++; $display("FAIL b2b_proc_num: got %0b expected 1", pn); end
  endtask

  task automatic test_reset_mid_run();
    checks++; if (proc_num !== 1'b1) begin errors++; $display("FAIL mid_pre_proc_num: got %0b expected 1", proc_num); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (proc_num !== 1'b0) begin errors++; $display("FAIL mid_proc_num: got %0b expected 0", proc_num); end
    checks++; if (trap_irq !== 1'b0) begin errors++; $display("FAIL mid_trap_irq: got %0b expected 0", trap_irq); end
    checks++; if (cur_pid !== 2'd0) begin errors++; $display("FAIL mid_cur_pid: got %0d expected 0", cur_pid); end
    reset = 1'b1;
    do_dispatch(2'd2, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h000) begin errors++; $display("FAIL mid_tbl2_cleared: got %h expected 000", spc); end
    do_syscall(10'h0CC);
    do_dispatch(2'd3, 8'd0, spc, chg, pn);
    checks++; if (spc !== 10'h000) begin errors++; $display("FAIL mid_tbl3_cleared: got %h expected 000", spc); end
    do_syscall(10'h0DD);
  endtask

  initial begin
    reset = 1'b0; hlt = 1'b0; dispatch_req = 1'b0; dispatch_pid = '0; quantum_in = '0;
    syscall = 1'b0; proc_exit = 1'b0; proc_pc = '0; tbl_we = 1'b0; tbl_pid = '0; tbl_pc = '0;
    test_reset();
    test_preset_dispatch();
    test_write_in_dispatch_cycle();
    test_hlt_dispatch_ignored();
    test_quantum();
    test_exit_priority();
    test_collision();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
